// File: rtl/l2_cache_dm.sv
// Direct-mapped, write-back, write-allocate L2 cache controller with built-in
// tag/valid/dirty/line storage (registered read port with write-to-read bypass).
module l2_cache_dm #(
  parameter int s_index  = 3,
  parameter int s_offset = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [31:0]                   mem_address,
  input  logic [8*(2**s_offset)-1:0]    mem_wdata,
  output logic [8*(2**s_offset)-1:0]    mem_rdata,
  output logic                          mem_resp,
  output logic                          pmem_read,
  output logic                          pmem_write,
  output logic [31:0]                   pmem_address,
  output logic [8*(2**s_offset)-1:0]    pmem_wdata,
  input  logic [8*(2**s_offset)-1:0]    pmem_rdata,
  input  logic                          pmem_resp
);
  localparam int num_sets = 2**s_index;
  localparam int line_w   = 8*(2**s_offset);
  localparam int s_tag    = 32 - s_index - s_offset;

  // Handshake: mem_read/mem_write are held by the requester until the single
  // mem_resp pulse; pmem_read/pmem_write are held here until the single pmem_resp pulse.
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;
  state_t state, next_state;

  logic [s_tag-1:0]   req_tag;
  logic [s_index-1:0] req_index;
  logic               unused_offset;

  logic [s_tag-1:0]   lat_tag;
  logic [s_index-1:0] lat_index;
  logic [line_w-1:0]  lat_wdata;
  logic               lat_write;
  logic               latch_en;

  logic               rd_en;
  logic [s_index-1:0] rd_index;
  logic [s_tag-1:0]   rd_tag;
  logic               rd_valid;
  logic               rd_dirty;
  logic [line_w-1:0]  rd_line;

  logic               ld_line, ld_tag, ld_valid, ld_dirty, ld_dirty_val;
  logic [line_w-1:0]  ld_line_data;
  logic               ld_same;
  logic               hit;

  logic [s_tag-1:0]   tag_mem  [num_sets];
  logic [line_w-1:0]  line_mem [num_sets];
  logic [num_sets-1:0] valid_q;
  logic [num_sets-1:0] dirty_q;

  assign req_tag       = mem_address[31:s_offset+s_index];
  assign req_index     = mem_address[s_offset+s_index-1:s_offset];
  assign unused_offset = ^mem_address[s_offset-1:0];
  assign hit           = rd_valid && (rd_tag == lat_tag);
  assign ld_same       = (lat_index == rd_index);
  assign mem_rdata     = rd_line;

  always_comb begin
    next_state   = state;
    latch_en     = 1'b0;
    rd_en        = 1'b0;
    rd_index     = lat_index;
    ld_line      = 1'b0;
    ld_tag       = 1'b0;
    ld_valid     = 1'b0;
    ld_dirty     = 1'b0;
    ld_dirty_val = 1'b0;
    ld_line_data = lat_wdata;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {lat_tag, lat_index, {s_offset{1'b0}}};
    pmem_wdata   = rd_line;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          latch_en   = 1'b1;
          rd_en      = 1'b1;
          rd_index   = req_index;
          next_state = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          mem_resp = 1'b1;
          if (lat_write) begin
            ld_line      = 1'b1;
            ld_dirty     = 1'b1;
            ld_dirty_val = 1'b1;
          end
          next_state = IDLE;
        end else if (rd_valid && rd_dirty) begin
          next_state = WRITEBACK;
        end else begin
          next_state = FILL;
        end
      end
      WRITEBACK: begin
        // Victim tag and line stay in the read registers: no array read happens here.
        pmem_write   = 1'b1;
        pmem_address = {rd_tag, lat_index, {s_offset{1'b0}}};
        if (pmem_resp) begin
          ld_dirty   = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          ld_line      = 1'b1;
          ld_line_data = pmem_rdata;
          ld_tag       = 1'b1;
          ld_valid     = 1'b1;
          ld_dirty     = 1'b1;
          rd_en        = 1'b1;
          next_state   = COMPARE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_tag   <= '0;
      lat_index <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
    end else if (latch_en) begin
      lat_tag   <= req_tag;
      lat_index <= req_index;
      lat_wdata <= mem_wdata;
      lat_write <= mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_line) line_mem[lat_index] <= ld_line_data;
    if (ld_tag)  tag_mem[lat_index]  <= lat_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (ld_valid) valid_q[lat_index] <= 1'b1;
      if (ld_dirty) dirty_q[lat_index] <= ld_dirty_val;
    end
  end

  // Registered read port; a same-cycle load to the same set wins (bypass).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_tag   <= '0;
      rd_valid <= 1'b0;
      rd_dirty <= 1'b0;
      rd_line  <= '0;
    end else if (rd_en) begin
      rd_tag   <= (ld_tag   && ld_same) ? lat_tag      : tag_mem[rd_index];
      rd_valid <= (ld_valid && ld_same) ? 1'b1         : valid_q[rd_index];
      rd_dirty <= (ld_dirty && ld_same) ? ld_dirty_val : dirty_q[rd_index];
      rd_line  <= (ld_line  && ld_same) ? ld_line_data : line_mem[rd_index];
    end
  end
endmodule

// File: tb/tb_l2_cache_dm.sv
// Bench for l2_cache_dm: directed vector table, reset-abandon sequence, and
// random traffic against a set-level cache/memory reference model.
module tb_l2_cache_dm;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_read, mem_write;
  logic [31:0]   mem_address;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic          mem_resp, pmem_read, pmem_write;
  logic [31:0]   pmem_address;
  logic [LW-1:0] pmem_wdata, pmem_rdata;
  logic          pmem_resp;

  l2_cache_dm dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  localparam logic [LW-1:0] LINE_A = {8{32'haaaa_0040}};
  localparam logic [LW-1:0] LINE_B = {8{32'hbbbb_0140}};
  localparam logic [LW-1:0] LINE_D = {8{32'hdddd_0360}};
  localparam logic [LW-1:0] LINE_W = {8{32'h1234_5678}};
  localparam logic [LW-1:0] LINE_C = {8{32'hcccc_0260}};

  typedef struct {
    bit            hit;
    bit            wb;
    logic [31:0]   wb_addr;
    logic [LW-1:0] wb_data;
    logic [31:0]   fill_addr;
    logic [LW-1:0] rdata;
    int            lat;
  } pred_t;

  typedef struct {
    bit            wr;
    logic [31:0]   addr;
    logic [LW-1:0] wdata;
    bit            hit;
    bit            wb;
    logic [31:0]   wb_addr;
    logic [LW-1:0] wb_data;
    logic [LW-1:0] rdata;
    int            lat;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [LW-1:0] pmem_model [logic [31:0]];
  logic [LW-1:0] ref_data   [logic [31:0]];
  bit            rv   [8];
  bit            rdty [8];
  logic [23:0]   rt   [8];
  logic [LW-1:0] exp_q[$];

  task automatic report();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] default_line(input logic [31:0] a);
    logic [LW-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = a ^ (32'h5a5a_0000 + 32'(i));
    return l;
  endfunction

  // What the whole system (cache + memory) should return for a line.
  function automatic logic [LW-1:0] coherent_line(input logic [31:0] la);
    if (ref_data.exists(la))   return ref_data[la];
    if (pmem_model.exists(la)) return pmem_model[la];
    return default_line(la);
  endfunction

  task automatic model_step(input bit wr, input logic [31:0] addr, input logic [LW-1:0] wd,
                            output pred_t p);
    logic [2:0]  set;
    logic [23:0] tag;
    logic [31:0] la;
    set = addr[7:5];
    tag = addr[31:8];
    la  = {addr[31:5], 5'b0};
    p.hit       = rv[set] && (rt[set] == tag);
    p.wb        = !p.hit && rv[set] && rdty[set];
    p.wb_addr   = {rt[set], set, 5'b0};
    p.wb_data   = p.wb ? coherent_line(p.wb_addr) : '0;
    p.fill_addr = la;
    p.lat       = p.hit ? 1 : -1;
    if (!p.hit) begin
      rv[set]   = 1'b1;
      rt[set]   = tag;
      rdty[set] = 1'b0;
    end
    if (wr) begin
      ref_data[la] = wd;
      rdty[set]    = 1'b1;
    end
    p.rdata = coherent_line(la);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      rv[i]   = 1'b0;
      rdty[i] = 1'b0;
    end
    ref_data.delete();
  endtask

  // Drives one request from a negedge and plays the memory side until mem_resp.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [LW-1:0] wd,
                        input int fw, output logic [LW-1:0] rd, output int lat,
                        output int n_wb, output logic [31:0] wb_addr, output logic [LW-1:0] wb_data,
                        output int n_fill, output logic [31:0] fill_addr, output int sum_w);
    bit            pend = 1'b0, pend_wr = 1'b0, done = 1'b0;
    int            cnt = 0;
    logic [31:0]   p_addr = '0;
    logic [LW-1:0] p_data = '0;
    rd = '0; lat = 0; n_wb = 0; n_fill = 0; sum_w = 0;
    wb_addr = '0; wb_data = '0; fill_addr = '0;
    mem_read = !wr; mem_write = wr; mem_address = addr; mem_wdata = wd;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        pend = 1'b0;
      end
      chk("pmem_excl", LW'(pmem_read & pmem_write), '0);
      if (mem_resp) begin
        rd = mem_rdata;
        mem_read = 1'b0;
        mem_write = 1'b0;
        done = 1'b1;
      end else if (pmem_read || pmem_write) begin
        if (!pend) begin
          pend = 1'b1; pend_wr = pmem_write;
          p_addr = pmem_address; p_data = pmem_wdata;
          cnt = (fw >= 0) ? fw : int'($urandom_range(0, 3));
          sum_w += cnt + 1;
          if (pmem_write) begin
            n_wb++; wb_addr = pmem_address; wb_data = pmem_wdata;
          end else begin
            n_fill++; fill_addr = pmem_address;
          end
        end else begin
          chk("pmem_hold_addr", LW'(pmem_address), LW'(p_addr));
          if (pend_wr) chk("pmem_hold_wdata", pmem_wdata, p_data);
        end
        if (cnt == 0) begin
          pmem_resp = 1'b1;
          if (pend_wr) pmem_model[p_addr] = p_data;
          else begin
            if (!pmem_model.exists(p_addr)) pmem_model[p_addr] = default_line(p_addr);
            pmem_rdata = pmem_model[p_addr];
          end
        end else cnt--;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL req_timeout: got no mem_resp for addr %h after %0d cycles", addr, lat);
      report();
    end
    @(negedge clk);
    pmem_resp = 1'b0;
  endtask

  task automatic run_and_check(input string nm, input bit wr, input logic [31:0] addr,
                               input logic [LW-1:0] wd, input int fw, input pred_t p);
    logic [LW-1:0] rd, wb_data;
    logic [31:0]   wb_addr, fill_addr;
    int            lat, n_wb, n_fill, sum_w, exp_lat;
    do_req(wr, addr, wd, fw, rd, lat, n_wb, wb_addr, wb_data, n_fill, fill_addr, sum_w);
    exp_lat = (p.lat >= 0) ? p.lat : 2 + sum_w;
    chk({nm, ".lat"},    LW'(lat),    LW'(exp_lat));
    chk({nm, ".n_wb"},   LW'(n_wb),   LW'(p.wb ? 1 : 0));
    chk({nm, ".n_fill"}, LW'(n_fill), LW'(p.hit ? 0 : 1));
    if (p.wb) begin
      chk({nm, ".wb_addr"}, LW'(wb_addr), LW'(p.wb_addr));
      chk({nm, ".wb_data"}, wb_data, p.wb_data);
    end
    if (!p.hit) chk({nm, ".fill_addr"}, LW'(fill_addr), LW'(p.fill_addr));
    if (!wr) begin
      exp_q.push_back(p.rdata);
      chk({nm, ".rdata"}, rd, exp_q.pop_front());
    end
  endtask

  initial begin
    vec_t  vt[9];
    pred_t p, mp;
    bit    seen;

    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("reset.mem_resp",   LW'(mem_resp),   '0);
    chk("reset.pmem_read",  LW'(pmem_read),  '0);
    chk("reset.pmem_write", LW'(pmem_write), '0);
    chk("reset.mem_rdata",  mem_rdata,       '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    pmem_model[32'h40]  = LINE_A;
    pmem_model[32'h140] = LINE_B;
    pmem_model[32'h360] = LINE_D;

    //          wr  addr        wdata   hit wb  wb_addr     wb_data rdata   lat
    vt[0] = '{1'b0, 32'h40,  '0,     1'b0, 1'b0, 32'h0,   '0,     LINE_A, 6};
    vt[1] = '{1'b0, 32'h44,  '0,     1'b1, 1'b0, 32'h0,   '0,     LINE_A, 1};
    vt[2] = '{1'b1, 32'h40,  LINE_W, 1'b1, 1'b0, 32'h0,   '0,     '0,     1};
    vt[3] = '{1'b0, 32'h40,  '0,     1'b1, 1'b0, 32'h0,   '0,     LINE_W, 1};
    vt[4] = '{1'b0, 32'h140, '0,     1'b0, 1'b1, 32'h40,  LINE_W, LINE_B, 10};
    vt[5] = '{1'b0, 32'h40,  '0,     1'b0, 1'b0, 32'h0,   '0,     LINE_W, 6};
    vt[6] = '{1'b1, 32'h260, LINE_C, 1'b0, 1'b0, 32'h0,   '0,     '0,     6};
    vt[7] = '{1'b0, 32'h260, '0,     1'b1, 1'b0, 32'h0,   '0,     LINE_C, 1};
    vt[8] = '{1'b0, 32'h360, '0,     1'b0, 1'b1, 32'h260, LINE_C, LINE_D, 10};

    for (int i = 0; i < 9; i++) begin
      model_step(vt[i].wr, vt[i].addr, vt[i].wdata, mp);
      p.hit       = vt[i].hit;
      p.wb        = vt[i].wb;
      p.wb_addr   = vt[i].wb_addr;
      p.wb_data   = vt[i].wb_data;
      p.fill_addr = {vt[i].addr[31:5], 5'b0};
      p.rdata     = vt[i].rdata;
      p.lat       = vt[i].lat;
      run_and_check($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wdata, 3, p);
    end

    // Reset while filling: request is abandoned, a stray pmem_resp is ignored.
    mem_read = 1'b1;
    mem_address = 32'h540;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (pmem_read) seen = 1'b1;
    end
    chk("rstseq.fill_seen", LW'(seen), LW'(1'b1));
    chk("rstseq.fill_addr", LW'(pmem_address), LW'(32'h540));
    #2 rst = 1'b1;
    #1;
    chk("rstseq.pmem_read",  LW'(pmem_read),  '0);
    chk("rstseq.pmem_write", LW'(pmem_write), '0);
    chk("rstseq.mem_resp",   LW'(mem_resp),   '0);
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pmem_rdata = {8{32'hdead_beef}};
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rstseq.quiet%0d", k), LW'({pmem_read, pmem_write, mem_resp}), '0);
      @(negedge clk);
    end
    model_reset();
    model_step(1'b0, 32'h40, '0, p);
    chk("rstseq.model_miss", LW'(p.hit), '0);
    run_and_check("rstseq.reread", 1'b0, 32'h40, '0, 1, p);

    for (int n = 0; n < 300; n++) begin
      bit            wr;
      logic [31:0]   addr;
      logic [LW-1:0] wd;
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31);
      for (int j = 0; j < 8; j++) wd[j*32 +: 32] = $urandom;
      model_step(wr, addr, wd, p);
      run_and_check($sformatf("rnd%0d", n), wr, addr, wd, -1, p);
    end

    report();
  end
endmodule
